// File: rtl/board_streamer.sv
// Snapshots the live board on each accepted generation tick, computes population and
// still-life status one row per cycle, then streams the board out row by row (valid/ready).
module board_streamer #(
    parameter int N     = 16,
    parameter int GEN_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N*N-1:0]          cells,
    input  logic                    gen_tick,
    output logic [N-1:0]            row_data,
    output logic [$clog2(N)-1:0]    row_idx,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic                    frame_last,
    output logic [GEN_W-1:0]        gen_count,
    output logic [$clog2(N*N):0]    pop_count,
    output logic                    still,
    output logic                    extinct,
    output logic                    busy,
    output logic                    overrun
);

    localparam int RW = $clog2(N);
    localparam int PW = $clog2(N*N) + 1;

    typedef enum logic [1:0] {IDLE, COUNT, STREAM} state_t;

    state_t           state_q, state_d;
    logic [N*N-1:0]   snap_q, snap_d;
    logic [N*N-1:0]   prev_q, prev_d;
    logic [RW-1:0]    row_q, row_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic             diff_q, diff_d;
    logic             have_prev_q, have_prev_d;
    logic [GEN_W-1:0] gen_count_q, gen_count_d;
    logic [PW-1:0]    pop_count_q, pop_count_d;
    logic             still_q, still_d;
    logic             extinct_q, extinct_d;
    logic             overrun_q, overrun_d;

    logic [N-1:0]     snap_row;
    logic [N-1:0]     prev_row;
    logic [PW-1:0]    row_pop;
    logic             last_row;
    logic [PW-1:0]    total;
    logic             diff_total;

    always_comb begin
        snap_row   = snap_q[int'(row_q)*N +: N];
        prev_row   = prev_q[int'(row_q)*N +: N];
        last_row   = (row_q == RW'(N-1));
        row_pop    = '0;
        for (int unsigned j = 0; j < N; j++) begin
            row_pop = row_pop + PW'(snap_row[j]);
        end
        total      = acc_q + row_pop;
        diff_total = diff_q | (snap_row != prev_row);
    end

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        prev_d      = prev_q;
        row_d       = row_q;
        acc_d       = acc_q;
        diff_d      = diff_q;
        have_prev_d = have_prev_q;
        gen_count_d = gen_count_q;
        pop_count_d = pop_count_q;
        still_d     = still_q;
        extinct_d   = extinct_q;
        overrun_d   = overrun_q;

        // A tick arriving in COUNT or STREAM is dropped and recorded, never queued.
        if (gen_tick && state_q != IDLE) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (gen_tick) begin
                    prev_d      = snap_q;
                    snap_d      = cells;
                    gen_count_d = gen_count_q + GEN_W'(1);
                    row_d       = '0;
                    acc_d       = '0;
                    diff_d      = 1'b0;
                    state_d     = COUNT;
                end
            end
            COUNT: begin
                acc_d  = total;
                diff_d = diff_total;
                if (last_row) begin
                    pop_count_d = total;
                    extinct_d   = (total == '0);
                    still_d     = have_prev_q & ~diff_total;
                    have_prev_d = 1'b1;
                    row_d       = '0;
                    state_d     = STREAM;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            STREAM: begin
                if (row_ready) begin
                    if (last_row) begin
                        row_d   = '0;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            prev_q      <= '0;
            row_q       <= '0;
            acc_q       <= '0;
            diff_q      <= 1'b0;
            have_prev_q <= 1'b0;
            gen_count_q <= '0;
            pop_count_q <= '0;
            still_q     <= 1'b0;
            extinct_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            prev_q      <= prev_d;
            row_q       <= row_d;
            acc_q       <= acc_d;
            diff_q      <= diff_d;
            have_prev_q <= have_prev_d;
            gen_count_q <= gen_count_d;
            pop_count_q <= pop_count_d;
            still_q     <= still_d;
            extinct_q   <= extinct_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        row_valid  = (state_q == STREAM);
        row_data   = row_valid ? snap_row : '0;
        row_idx    = row_q;
        frame_last = row_valid & last_row;
        busy       = (state_q != IDLE);
        gen_count  = gen_count_q;
        pop_count  = pop_count_q;
        still      = still_q;
        extinct    = extinct_q;
        overrun    = overrun_q;
    end

endmodule

// File: tb/tb_board_streamer.sv
// Directed bench for board_streamer at N=4: table of whole frames plus hand sequences
// for backpressure, dropped ticks and mid-stream reset.
module tb_board_streamer;

    localparam int N     = 4;
    localparam int GEN_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [N*N-1:0]    cells;
    logic              gen_tick;
    logic [N-1:0]      row_data;
    logic [1:0]        row_idx;
    logic              row_valid;
    logic              row_ready;
    logic              frame_last;
    logic [GEN_W-1:0]  gen_count;
    logic [4:0]        pop_count;
    logic              still;
    logic              extinct;
    logic              busy;
    logic              overrun;

    int n_vec = 0;
    int n_err = 0;

    board_streamer #(.N(N), .GEN_W(GEN_W)) dut (
        .clk(clk), .reset(reset), .cells(cells), .gen_tick(gen_tick),
        .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid),
        .row_ready(row_ready), .frame_last(frame_last), .gen_count(gen_count),
        .pop_count(pop_count), .still(still), .extinct(extinct), .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      cells;
        logic [3:0][3:0]  rows;
        int unsigned      pop;
        logic             still;
        logic             extinct;
        int unsigned      gen;
    } frame_t;

    frame_t vec [6];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: pulse tick for one edge, return at the negedge after it.
    task automatic pulse_tick(input logic [15:0] c);
        cells    = c;
        gen_tick = 1'b1;
        @(negedge clk);
        gen_tick = 1'b0;
    endtask

    // Counts cycles from the tick edge until row_valid appears (bounded).
    task automatic wait_valid(input string name, input int unsigned exp_lat);
        int unsigned k = 1;
        while (!row_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(name, k, exp_lat);
    endtask

    task automatic expect_row(input string name, input int unsigned idx, input logic [3:0] data);
        check({name, " valid"}, row_valid, 1);
        check({name, " idx"}, row_idx, idx);
        check({name, " data"}, row_data, data);
        check({name, " last"}, frame_last, (idx == 3) ? 1 : 0);
    endtask

    task automatic expect_idle(input string name);
        check({name, " valid_off"}, row_valid, 0);
        check({name, " busy_off"}, busy, 0);
    endtask

    initial begin
        reset     = 1'b0;
        cells     = '0;
        gen_tick  = 1'b0;
        row_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst valid", row_valid, 0);
        check("rst busy", busy, 0);
        check("rst gen", gen_count, 0);
        check("rst pop", pop_count, 0);
        check("rst still", still, 0);
        check("rst extinct", extinct, 0);
        check("rst overrun", overrun, 0);
        check("rst last", frame_last, 0);
        reset = 1'b1;
        @(negedge clk);

        vec[0] = '{cells: 16'h0660, rows: {4'h0, 4'h6, 4'h6, 4'h0}, pop: 4,  still: 0, extinct: 0, gen: 1};
        vec[1] = '{cells: 16'h0660, rows: {4'h0, 4'h6, 4'h6, 4'h0}, pop: 4,  still: 1, extinct: 0, gen: 2};
        vec[2] = '{cells: 16'h0270, rows: {4'h0, 4'h2, 4'h7, 4'h0}, pop: 4,  still: 0, extinct: 0, gen: 3};
        vec[3] = '{cells: 16'h0000, rows: {4'h0, 4'h0, 4'h0, 4'h0}, pop: 0,  still: 0, extinct: 1, gen: 4};
        vec[4] = '{cells: 16'hFFFF, rows: {4'hF, 4'hF, 4'hF, 4'hF}, pop: 16, still: 0, extinct: 0, gen: 5};
        vec[5] = '{cells: 16'hFFFF, rows: {4'hF, 4'hF, 4'hF, 4'hF}, pop: 16, still: 1, extinct: 0, gen: 6};

        for (int i = 0; i < 6; i++) begin
            pulse_tick(vec[i].cells);
            check("count busy", busy, 1);
            check("count valid_off", row_valid, 0);
            // Cells wander after the tick; only the snapshot may show up downstream.
            cells = ~vec[i].cells;
            wait_valid("latency", 5);
            for (int r = 0; r < 4; r++) begin
                expect_row("vec row", r, vec[i].rows[r]);
                @(negedge clk);
            end
            expect_idle("vec end");
            check("vec pop", pop_count, vec[i].pop);
            check("vec still", still, vec[i].still);
            check("vec extinct", extinct, vec[i].extinct);
            check("vec gen", gen_count, vec[i].gen);
            @(negedge clk);
        end

        // Backpressure on idx 1 for three cycles.
        pulse_tick(16'h0660);
        wait_valid("bp latency", 5);
        expect_row("bp row0", 0, 4'h0);
        @(negedge clk);
        row_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            expect_row("bp hold", 1, 4'h6);
            @(negedge clk);
        end
        expect_row("bp hold end", 1, 4'h6);
        row_ready = 1'b1;
        @(negedge clk);
        expect_row("bp row2", 2, 4'h6);
        @(negedge clk);
        expect_row("bp row3", 3, 4'h0);
        @(negedge clk);
        expect_idle("bp end");
        check("bp gen", gen_count, 7);
        check("bp still", still, 0);

        // Tick dropped during STREAM.
        pulse_tick(16'h0270);
        row_ready = 1'b0;
        wait_valid("ovr latency", 5);
        check("ovr before", overrun, 0);
        pulse_tick(16'hFFFF);
        check("ovr set", overrun, 1);
        check("ovr gen", gen_count, 8);
        expect_row("ovr hold", 0, 4'h0);
        row_ready = 1'b1;
        @(negedge clk);
        expect_row("ovr row1", 1, 4'h7);
        @(negedge clk);
        expect_row("ovr row2", 2, 4'h2);
        @(negedge clk);
        expect_row("ovr row3", 3, 4'h0);
        @(negedge clk);
        expect_idle("ovr end");
        pulse_tick(16'hFFFF);
        wait_valid("ovr2 latency", 5);
        expect_row("ovr2 row0", 0, 4'hF);
        check("ovr2 still", still, 0);
        check("ovr2 pop", pop_count, 16);
        check("ovr2 gen", gen_count, 9);
        check("ovr sticky", overrun, 1);
        repeat (4) @(negedge clk);
        expect_idle("ovr2 end");

        // Reset at idx 2 of a frame that would otherwise be still.
        pulse_tick(16'hFFFF);
        wait_valid("rst latency", 5);
        @(negedge clk);
        @(negedge clk);
        expect_row("rst row2", 2, 4'hF);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        expect_idle("mid rst");
        check("mid rst gen", gen_count, 0);
        check("mid rst pop", pop_count, 0);
        check("mid rst overrun", overrun, 0);
        check("mid rst still", still, 0);
        @(negedge clk);
        pulse_tick(16'hFFFF);
        wait_valid("post rst latency", 5);
        expect_row("post rst row0", 0, 4'hF);
        check("post rst still", still, 0);
        check("post rst gen", gen_count, 1);
        check("post rst pop", pop_count, 16);
        repeat (4) @(negedge clk);
        expect_idle("post rst end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/board_streamer.md
Name: board_streamer

Overview:
- Downstream consumer of the toroidal cell array.
- On each generation tick it snapshots the N*N live-cell vector and computes population and still-life/extinction status sequentially, one row per cycle.
- It then streams the board out row by row over a valid/ready interface to a display or host link.
- It also tracks the generation count and flags ticks it had to drop.

Parameters:
- N, 16, board side length; cell vector width is N*N.
- GEN_W, 16, generation counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- cells  in  N*N  live board from the cell array; bit r*N+j is row r, column j.
- gen_tick  in  1  one-cycle pulse; cells holds a new generation this cycle.
- row_data  out  N  current row; bit j = cells[r*N+j] of the snapshot.
- row_idx  out  $clog2(N)  index r of row_data.
- row_valid  out  1  row_data/row_idx valid.
- row_ready  in  1  sink accepts the row.
- frame_last  out  1  high with row_valid on row N-1.
- gen_count  out  GEN_W  accepted generations.
- pop_count  out  $clog2(N*N)+1  live cells in the last completed snapshot.
- still  out  1  last snapshot identical to the previous one.
- extinct  out  1  last snapshot has pop 0.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky; a gen_tick was dropped.

Behaviour:
- **Reset** (reset low at a clk edge): state IDLE. All outputs 0. Internal snap, prev, row counter and accumulator cleared; have_prev=0. Reset applied mid-COUNT or mid-STREAM aborts; row_valid is 0 the cycle after.
- **States:** IDLE, COUNT, STREAM.
- **IDLE:**
  - gen_tick=1 at an edge: prev<=snap, snap<=cells, gen_count<=gen_count+1 (wraps 2^GEN_W-1 -> 0), row counter<=0, accumulator<=0, diff flag<=0, go COUNT.
- **COUNT:** lasts exactly N cycles, one row r per cycle.
  - Accumulate popcount of snap row r.
  - OR diff flag with (snap row r != prev row r).
  - At the edge ending row N-1:
    - pop_count<=total.
    - extinct<=(total==0).
    - still<=have_prev & !diff.
    - have_prev<=1.
    - row counter<=0; go STREAM.
  - pop_count/still/extinct hold their old values until this edge.
- **STREAM:**
  - row_valid=1, row_data=snap row r, row_idx=r, frame_last=(r==N-1).
  - Transfer occurs when row_valid & row_ready at an edge; r increments.
  - Transfer of row N-1 -> IDLE; row_valid=0 the next cycle.
  - While row_ready=0, row_data/row_idx/frame_last are held stable and row_valid stays high (no retraction).
- **Latency:** gen_tick sampled at edge E0 -> row_valid first high in the cycle after edge E0+N (N+1 cycles after the tick cycle). With row_ready held high, the frame completes in N further cycles.
- **gen_tick while busy:**
  - Ignored: snap, prev and gen_count are unchanged; the in-flight frame is unaffected.
  - overrun<=1, and stays 1 until reset.
  - gen_tick in IDLE on the same edge busy falls is not possible (busy falls only on entering IDLE).
- **Snapshot isolation:** cells changing at any time other than an accepted gen_tick has no effect on outputs.
- **First frame after reset:** still=0 regardless of content.
- busy = (state != IDLE), registered via state.

Test Plan:
1. N=4, cells=16'h0660, gen_tick pulse, row_ready=1 -> row_valid rises 5 cycles after the tick. Rows idx0..3 = 0x0,0x6,0x6,0x0; frame_last only on idx3. pop_count=4, gen_count=1, still=0, extinct=0. busy low after the 4th row.
2. Same cells, second gen_tick after IDLE -> gen_count=2, still=1, pop_count=4. Then cells=16'h0270 and a third tick -> still=0, pop_count=4, rows 0x0,0x7,0x2,0x0.
3. Backpressure: row_ready=0 for 3 cycles while idx=1 is presented -> row_valid stays 1, row_data=0x6 and row_idx=1 held. Transfer completes on the first ready-high edge; no row skipped or duplicated.
4. gen_tick during STREAM with cells=16'hFFFF -> overrun=1. gen_count unchanged. Remaining rows still from the old snapshot. Next frame after a fresh tick reflects the new cells. overrun remains 1.
5. cells=16'h0000, gen_tick -> pop_count=0, extinct=1, all four rows 0x0.
6. reset driven low during STREAM at idx=2 -> next cycle row_valid=0, busy=0, gen_count=0, pop_count=0, overrun=0. Next tick after release gives still=0 (have_prev cleared).
